uart_boot_loader: RTL and testbench
===================================

# uart_boot_loader

Serial program loader sitting directly upstream of the Lipsi processor. It receives a framed program image over a UART RX line, writes each byte into the processor's unified instruction/data memory at consecutive addresses from 0, and verifies a checksum. The processor is held in reset until a load completes successfully, then released to fetch from address 0.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4.
- ADDR_W, 8: memory address width; image length is limited to 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- uart_rx  in  1  serial input, idle high, 8N1, LSB first; asynchronous to clk.
- mem_wr_en  out  1  one-cycle write strobe to memory.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  8  write data.
- cpu_hold  out  1  active-high reset to the processor; 1 until a successful load.
- load_done  out  1  level; 1 after a checksum match.
- load_err  out  1  sticky; framing or checksum error since last length byte.

## Operation
- Frame: LEN byte (0x00 means 2^ADDR_W, else 1..255), LEN data bytes, SUM byte = 8-bit modulo-256 sum of the data bytes.
- RX path: uart_rx through a 2-flop synchronizer. Idle→start on a synchronized 1→0. Start re-checked at CLKS_PER_BIT/2 (integer division); if high, false start, return to idle, no byte. Data bits sampled at bit centres (every CLKS_PER_BIT after the start-centre), LSB first. Stop bit sampled at its centre: 1 → rx_valid internal pulse (1 cycle) with the byte; 0 → framing error, byte discarded, rx returns to idle after the stop-bit sample and waits for line high before accepting a new start.
- Loader FSM states: WAIT_LEN, LOAD, WAIT_SUM, DONE.
- WAIT_LEN: on rx_valid, latch remaining = LEN (0 → 2^ADDR_W), address = 0, sum = 0, clear load_err, go LOAD.
- LOAD: on rx_valid, issue write (addr, byte), sum += byte (mod 256), address += 1, remaining −= 1; when remaining reaches 0 go WAIT_SUM.
- WAIT_SUM: on rx_valid, match → DONE; mismatch → set load_err, go WAIT_LEN.
- Framing error in LOAD or WAIT_SUM: set load_err, go WAIT_LEN (bytes already written stay in memory). Framing error in WAIT_LEN: set load_err, stay.
- DONE: cpu_hold = 0, load_done = 1; RX continues running but all bytes ignored, no writes. Terminal until reset.
- cpu_hold is 1 in every state except DONE; the processor never executes a partial or failed image.
- Address wrap: with LEN = 0x00 the last write goes to 0xFF; address counter wrap to 0 is not used for a write.

## Timing
- Reset (reset = 0, asynchronous): FSM WAIT_LEN, RX idle, mem_wr_en = 0, mem_wr_addr = 0, mem_wr_data = 0, cpu_hold = 1, load_done = 0, load_err = 0. Reset mid-byte or mid-frame aborts everything; no write strobe emitted after reset assertion.
- rx_valid asserts the cycle after the stop-bit centre sample; ~9.5 bit times plus 2 synchronizer cycles after the start-bit falling edge.
- mem_wr_en/addr/data registered: asserted exactly one cycle after rx_valid, high for exactly one cycle; addr/data hold their values until the next write.
- Minimum write spacing = one UART frame; memory sees at most one write per CLKS_PER_BIT×10 cycles.
- On SUM match: load_done 1 and cpu_hold 0 in the same cycle, one cycle after rx_valid of SUM. load_err sets one cycle after the offending rx_valid / stop sample.
- No back-pressure; memory must accept every strobe.

## Test plan
- CLKS_PER_BIT=4: send 03, 11, 22, 33, 66 → writes (0,11),(1,22),(2,33), each 1-cycle strobe; load_done=1, cpu_hold=0, load_err=0.
- Send 02, 10, 20, 31 → two writes, then load_err=1, cpu_hold=1, FSM in WAIT_LEN; follow with 01, 5A, 5A → write (0,5A), load_done=1, load_err=0.
- Send 02, 10, then byte with stop bit 0 → one write only, load_err=1, WAIT_LEN; next good frame loads normally.
- 1-cycle-per-half-bit low glitch on uart_rx (shorter than CLKS_PER_BIT/2) → no rx_valid, no write, state unchanged.
- LEN=00 with 256 bytes 0x00..0xFF, SUM=0x80 → 256 writes, last at addr FF data FF, load_done=1.
- Drive reset=0 mid-data-byte in LOAD → outputs return to reset values immediately; after release, a full 01, 07, 07 frame gives write (0,07) and load_done=1; bytes after DONE produce no writes.

Source files
------------

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed program image (LEN, data bytes, SUM) on a
// 8N1 UART line and writes it to processor memory from address 0. The processor
// is held in reset until a complete image with a matching checksum has arrived.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   uart_rx      serial input, idle high, LSB first, asynchronous to clk
//   mem_wr_en    one-cycle memory write strobe
//   mem_wr_addr  write address (holds until the next write)
//   mem_wr_data  write data (holds until the next write)
//   cpu_hold     active-high processor reset, released only after a good load
//   load_done    level, set once the checksum matched
//   load_err     sticky framing/checksum error, cleared by the next length byte
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  // Wide enough for both a raw LEN byte and the 2^ADDR_W full-memory count.
  localparam int REM_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(1) << ADDR_W;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t        rx_state, rx_state_nxt;
  logic             rx_s1, rx_s2, rx_s3;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]       rx_bit, rx_bit_nxt;
  logic [7:0]       rx_shift, rx_shift_nxt;
  logic             rx_valid, rx_valid_nxt;
  logic             rx_ferr, rx_ferr_nxt;

  // rx_s1/rx_s2 form the synchronizer; rx_s3 is the previous synchronized
  // level, used only to detect the 1->0 start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
      rx_valid <= rx_valid_nxt;
      rx_ferr  <= rx_ferr_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + 1'b1;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_valid_nxt = 1'b0;
    rx_ferr_nxt  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nxt = '0;
        if (rx_s3 && !rx_s2) rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_M1) begin
          rx_cnt_nxt = '0;
          rx_bit_nxt = '0;
          // Line back high at mid-start: treat as a glitch.
          rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_M1) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_s2, rx_shift[7:1]};
          rx_bit_nxt   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_M1) begin
          rx_cnt_nxt = '0;
          if (rx_s2) begin
            rx_valid_nxt = 1'b1;
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_ferr_nxt  = 1'b1;
            rx_state_nxt = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A low line after a bad stop bit must not look like a new start.
        rx_cnt_nxt = '0;
        if (rx_s2) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    WAIT_LEN,
    LOAD,
    WAIT_SUM,
    DONE
  } ld_state_t;

  ld_state_t         state, state_nxt;
  logic [REM_W-1:0]  remaining, remaining_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [7:0]        sum, sum_nxt;
  logic              err_nxt;
  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [7:0]        wr_data_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_LEN;
      remaining   <= '0;
      wr_ptr      <= '0;
      sum         <= '0;
      load_err    <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      state       <= state_nxt;
      remaining   <= remaining_nxt;
      wr_ptr      <= wr_ptr_nxt;
      sum         <= sum_nxt;
      load_err    <= err_nxt;
      mem_wr_en   <= wr_en_nxt;
      mem_wr_addr <= wr_addr_nxt;
      mem_wr_data <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    wr_ptr_nxt    = wr_ptr;
    sum_nxt       = sum;
    err_nxt       = load_err;
    wr_en_nxt     = 1'b0;
    wr_addr_nxt   = mem_wr_addr;
    wr_data_nxt   = mem_wr_data;
    case (state)
      WAIT_LEN: begin
        if (rx_valid) begin
          remaining_nxt = (rx_shift == 8'd0) ? REM_FULL : REM_W'(rx_shift);
          wr_ptr_nxt    = '0;
          sum_nxt       = '0;
          err_nxt       = 1'b0;
          state_nxt     = LOAD;
        end else if (rx_ferr) begin
          err_nxt = 1'b1;
        end
      end
      LOAD: begin
        if (rx_valid) begin
          wr_en_nxt     = 1'b1;
          wr_addr_nxt   = wr_ptr;
          wr_data_nxt   = rx_shift;
          // After the last byte of a full-size image this wraps to 0 but is
          // never used for a write.
          wr_ptr_nxt    = wr_ptr + 1'b1;
          sum_nxt       = sum + rx_shift;
          remaining_nxt = remaining - 1'b1;
          if (remaining == REM_W'(1)) state_nxt = WAIT_SUM;
        end else if (rx_ferr) begin
          err_nxt   = 1'b1;
          state_nxt = WAIT_LEN;
        end
      end
      WAIT_SUM: begin
        if (rx_valid) begin
          if (rx_shift == sum) begin
            state_nxt = DONE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = WAIT_LEN;
          end
        end else if (rx_ferr) begin
          err_nxt   = 1'b1;
          state_nxt = WAIT_LEN;
        end
      end
      DONE: begin
        // Terminal: the receiver keeps running but its bytes are dropped.
      end
      default: state_nxt = WAIT_LEN;
    endcase
  end

  // Decoded straight from the state register so reset takes effect at once.
  assign cpu_hold  = (state != DONE);
  assign load_done = (state == DONE);

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  localparam int CPB    = 4;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              uart_rx = 1'b1;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [7:0]        mem_wr_data;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];   // {addr, data} of each expected write
  logic prev_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe is matched against the scoreboard and must last one cycle.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {8'h0, 8'(mem_wr_addr), mem_wr_data}, 32'h0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_wr_addr), 32'(e[15:8]));
        chk("wr_data", 32'(mem_wr_data), 32'(e[7:0]));
      end
      chk("strobe_width", 32'(prev_en), 32'h0);
    end
    prev_en = mem_wr_en;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] addr, input logic [7:0] data);
    exp_q.push_back({addr, data});
    send_byte(data, 1'b1);
  endtask

  task automatic glitch();
    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic chk_status(input string tag, input logic hold, input logic done, input logic err);
    chk({tag, ".cpu_hold"},  32'(cpu_hold),  32'(hold));
    chk({tag, ".load_done"}, 32'(load_done), 32'(done));
    chk({tag, ".load_err"},  32'(load_err),  32'(err));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".wr_en"},   32'(mem_wr_en),   32'h0);
    chk({tag, ".wr_addr"}, 32'(mem_wr_addr), 32'h0);
    chk({tag, ".wr_data"}, 32'(mem_wr_data), 32'h0);
    chk_status(tag, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] s;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 3-byte image with glitches in WAIT_LEN and LOAD that must be ignored.
    glitch();
    chk_status("glitch_idle", 1'b1, 1'b0, 1'b0);
    send_byte(8'h03, 1'b1);
    send_data(8'h00, 8'h11);
    glitch();
    chk_status("glitch_load", 1'b1, 1'b0, 1'b0);
    send_data(8'h01, 8'h22);
    send_data(8'h02, 8'h33);
    chk_status("pre_sum", 1'b1, 1'b0, 1'b0);
    send_byte(8'h66, 1'b1);
    chk_status("basic", 1'b0, 1'b1, 1'b0);

    // Checksum mismatch, then recovery with a good frame.
    do_reset();
    send_byte(8'h02, 1'b1);
    send_data(8'h00, 8'h10);
    send_data(8'h01, 8'h20);
    send_byte(8'h31, 1'b1);
    chk_status("bad_sum", 1'b1, 1'b0, 1'b1);
    send_byte(8'h01, 1'b1);
    chk_status("err_cleared_by_len", 1'b1, 1'b0, 1'b0);
    send_data(8'h00, 8'h5A);
    send_byte(8'h5A, 1'b1);
    chk_status("sum_recover", 1'b0, 1'b1, 1'b0);

    // Framing error on a data byte, then recovery.
    do_reset();
    send_byte(8'h02, 1'b1);
    send_data(8'h00, 8'h10);
    send_byte(8'h20, 1'b0);
    chk_status("framing", 1'b1, 1'b0, 1'b1);
    send_byte(8'h01, 1'b1);
    send_data(8'h00, 8'h77);
    send_byte(8'h77, 1'b1);
    chk_status("frame_recover", 1'b0, 1'b1, 1'b0);

    // Full-memory image: LEN=0 means 256 bytes.
    do_reset();
    send_byte(8'h00, 1'b1);
    s = 8'h00;
    for (int i = 0; i < 256; i++) begin
      send_data(8'(i), 8'(i));
      s = s + 8'(i);
    end
    chk("full_sum_model", 32'(s), 32'h80);
    send_byte(s, 1'b1);
    chk_status("full", 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a data byte.
    do_reset();
    send_byte(8'h02, 1'b1);
    send_data(8'h00, 8'h44);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB + 2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    repeat (3 * CPB) @(negedge clk);
    chk_reset_vals("mid_reset_hold");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h01, 1'b1);
    send_data(8'h00, 8'h07);
    send_byte(8'h07, 1'b1);
    chk_status("after_reset", 1'b0, 1'b1, 1'b0);
    // Bytes after DONE must not write (the monitor flags any strobe).
    send_byte(8'hAA, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    chk_status("done_terminal", 1'b0, 1'b1, 1'b0);

    repeat (20) @(negedge clk);
    chk("writes_outstanding", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
